// File: rtl/pwm_pkg.sv
`default_nettype none
// =============================================================================
// Package : pwm_pkg
// Brief   : Shared defaults and envelope direction type for the breathing PWM.
// Rev     : 1.0
// =============================================================================
package pwm_pkg;

    localparam int NCH_DEF        = 4;
    localparam int WIDTH_DEF      = 6;
    localparam int DIV_DEF        = 1;
    localparam int BREATH_PER_DEF = 4;

    typedef enum logic [0:0] {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_breathe_channel.sv
`default_nettype none
// =============================================================================
// Module : pwm_breathe_channel
// Brief  : One PWM channel: period shadows, triangle envelope, scaling, compare.
// Rev    : 1.0
// =============================================================================
module pwm_breathe_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int BREATH_PER = BREATH_PER_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wrap,
    input  logic             run,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] duty,
    input  logic             breathe,
    output logic             pwm
);

    localparam logic [WIDTH-1:0]   LEVEL_MAX = '1;
    localparam logic [WIDTH-1:0]   LEVEL_ONE = WIDTH'(1);
    localparam logic [7:0]         STEP_LAST = 8'(BREATH_PER - 1);
    localparam logic [2*WIDTH-1:0] PROD_ONE  = (2*WIDTH)'(1);

    logic [WIDTH-1:0]   duty_sh;
    logic [WIDTH-1:0]   duty_sh_nx;
    logic               breathe_sh;
    logic               breathe_sh_nx;
    logic [WIDTH-1:0]   env;
    logic [WIDTH-1:0]   env_nx;
    logic [WIDTH-1:0]   env_step;
    dir_e               dir;
    dir_e               dir_nx;
    dir_e               dir_step;
    logic [7:0]         step_div;
    logic [7:0]         step_div_nx;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   eff_duty;
    logic               pwm_nx;

    always_comb begin
        duty_sh_nx    = duty_sh;
        breathe_sh_nx = breathe_sh;
        env_nx        = env;
        dir_nx        = dir;
        step_div_nx   = step_div;

        // Direction flips as the envelope lands on an end value, so that value
        // is held for a full step interval before moving back.
        env_step = (dir == UP) ? env + LEVEL_ONE : env - LEVEL_ONE;
        dir_step = dir;
        if ((dir == UP) && (env_step == LEVEL_MAX)) begin
            dir_step = DOWN;
        end else if ((dir == DOWN) && (env_step == '0)) begin
            dir_step = UP;
        end

        if (wrap) begin
            duty_sh_nx    = duty;
            breathe_sh_nx = breathe;
            if (breathe) begin
                if (!breathe_sh) begin
                    env_nx      = '0;
                    dir_nx      = UP;
                    step_div_nx = '0;
                end else if (step_div == STEP_LAST) begin
                    step_div_nx = '0;
                    env_nx      = env_step;
                    dir_nx      = dir_step;
                end else begin
                    step_div_nx = step_div + 8'd1;
                end
            end
        end

        product  = {{WIDTH{1'b0}}, duty_sh} * ({{WIDTH{1'b0}}, env} + PROD_ONE);
        eff_duty = breathe_sh ? WIDTH'(product >> WIDTH) : duty_sh;
        pwm_nx   = run && ((eff_duty == LEVEL_MAX) || (cnt < eff_duty));
    end

    // Disable clears the shadows too, so re-enable behaves exactly like reset release.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            duty_sh    <= '0;
            breathe_sh <= 1'b0;
            env        <= '0;
            dir        <= UP;
            step_div   <= '0;
            pwm        <= 1'b0;
        end else begin
            duty_sh    <= duty_sh_nx;
            breathe_sh <= breathe_sh_nx;
            env        <= env_nx;
            dir        <= dir_nx;
            step_div   <= step_div_nx;
            pwm        <= pwm_nx;
        end
    end

endmodule : pwm_breathe_channel
`default_nettype wire

// File: rtl/pwm_breathe_multi.sv
`default_nettype none
// =============================================================================
// Module : pwm_breathe_multi
// Brief  : Multi-channel PWM with shared prescaler/period counter and breathing.
// Rev    : 1.0
// =============================================================================
module pwm_breathe_multi
    import pwm_pkg::*;
#(
    parameter int NCH        = NCH_DEF,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DIV        = DIV_DEF,
    parameter int BREATH_PER = BREATH_PER_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic [NCH*WIDTH-1:0] duty_i,
    input  logic [NCH-1:0]       breathe_i,
    output logic [NCH-1:0]       pwm_o,
    output logic                 period_tick_o
);

    localparam logic [15:0]      DIV_LAST = 16'(DIV - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = '1;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic [15:0]      pre_cnt;
    logic [WIDTH-1:0] cnt;
    logic             started;
    logic             tick;
    logic             wrap;

    // The first tick after enable is a wrap even though the counter sits at 0.
    assign tick = en_i && (pre_cnt == 16'd0);
    assign wrap = tick && (!started || (cnt == CNT_LAST));

    always_ff @(posedge clk) begin
        if (!rst_n || !en_i) begin
            pre_cnt       <= '0;
            cnt           <= '0;
            started       <= 1'b0;
            period_tick_o <= 1'b0;
        end else begin
            pre_cnt <= (pre_cnt == DIV_LAST) ? 16'd0 : pre_cnt + 16'd1;
            if (tick) begin
                started <= 1'b1;
                cnt     <= started ? cnt + CNT_ONE : '0;
            end
            period_tick_o <= wrap;
        end
    end

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_ch
            pwm_breathe_channel #(
                .WIDTH      (WIDTH),
                .BREATH_PER (BREATH_PER)
            ) u_ch (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (en_i),
                .wrap    (wrap),
                .run     (started),
                .cnt     (cnt),
                .duty    (duty_i[k*WIDTH +: WIDTH]),
                .breathe (breathe_i[k]),
                .pwm     (pwm_o[k])
            );
        end
    endgenerate

endmodule : pwm_breathe_multi
`default_nettype wire

// File: tb/tb_pwm_breathe_multi.sv
`default_nettype none
// =============================================================================
// Module : tb_pwm_breathe_multi
// Brief  : Bench for pwm_breathe_multi (DIV=1 and DIV=3 instances) with model.
// Rev    : 1.0
// =============================================================================
module tb_pwm_breathe_multi;

    localparam int BP = 4;

    logic        clk = 1'b0;
    logic        rst_a, en_a, rst_b, en_b;
    logic [23:0] duty_a, duty_b;
    logic [3:0]  br_a, br_b;
    logic [3:0]  pwm_a, pwm_b;
    logic        tick_a, tick_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    pwm_breathe_multi #(.NCH(4), .WIDTH(6), .DIV(1), .BREATH_PER(BP)) dut_a (
        .clk(clk), .rst_n(rst_a), .en_i(en_a), .duty_i(duty_a),
        .breathe_i(br_a), .pwm_o(pwm_a), .period_tick_o(tick_a));

    pwm_breathe_multi #(.NCH(4), .WIDTH(6), .DIV(3), .BREATH_PER(BP)) dut_b (
        .clk(clk), .rst_n(rst_b), .en_i(en_b), .duty_i(duty_b),
        .breathe_i(br_b), .pwm_o(pwm_b), .period_tick_o(tick_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model (time-since-enable arithmetic) -------
    bit         m_run[2];
    int         m_n[2];
    int         m_duty[2][4];
    bit         m_br[2][4];
    int         m_bstart[2][4];
    logic [3:0] exp_pwm[2];
    logic       exp_tick[2];

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Triangle envelope: 0..63 then 62..0, one value per step.
    function automatic int env_at(input int s);
        int m;
        m = s % 126;
        return (m <= 63) ? m : 126 - m;
    endfunction

    task automatic model_step(input int i, input logic rst, input logic en,
                              input logic [23:0] duty, input logic [3:0] br);
        int per, c_prev, p_prev, eff;
        per = 64 * div_of(i);
        if (!rst || !en) begin
            m_run[i]    = 1'b0;
            exp_pwm[i]  = '0;
            exp_tick[i] = 1'b0;
            for (int ch = 0; ch < 4; ch++) begin
                m_duty[i][ch] = 0;
                m_br[i][ch]   = 1'b0;
            end
        end else begin
            if (!m_run[i]) begin
                m_run[i]   = 1'b1;
                m_n[i]     = 0;
                exp_pwm[i] = '0;
            end else begin
                m_n[i]++;
                c_prev = ((m_n[i] - 1) / div_of(i)) % 64;
                p_prev = (m_n[i] - 1) / per;
                for (int ch = 0; ch < 4; ch++) begin
                    if (m_br[i][ch])
                        eff = (m_duty[i][ch] * (env_at((p_prev - m_bstart[i][ch]) / BP) + 1)) / 64;
                    else
                        eff = m_duty[i][ch];
                    exp_pwm[i][ch] = (eff == 63) || (c_prev < eff);
                end
            end
            exp_tick[i] = ((m_n[i] % per) == 0);
            if (exp_tick[i]) begin
                for (int ch = 0; ch < 4; ch++) begin
                    if (br[ch] && !m_br[i][ch]) m_bstart[i][ch] = m_n[i] / per;
                    m_duty[i][ch] = int'(duty[ch*6 +: 6]);
                    m_br[i][ch]   = br[ch];
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rst_a, en_a, duty_a, br_a);
        model_step(1, rst_b, en_b, duty_b, br_b);
    end

    // ---------------- compare + per-period high-count monitor ---------------
    int         hc[2][4];
    int         acc[2][4];
    int         ticks[2];
    int         gap[2];
    int         last_t[2];
    logic [3:0] mon_p;
    logic       mon_t;

    always @(posedge clk) begin
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            mon_p = (i == 0) ? pwm_a : pwm_b;
            mon_t = (i == 0) ? tick_a : tick_b;
            check((i == 0) ? "model_pwm_a" : "model_pwm_b", 32'(mon_p), 32'(exp_pwm[i]));
            check((i == 0) ? "model_tick_a" : "model_tick_b", 32'(mon_t), 32'(exp_tick[i]));
            for (int ch = 0; ch < 4; ch++) begin
                if (mon_t === 1'b1) begin
                    hc[i][ch]  = acc[i][ch] + int'(mon_p[ch] === 1'b1);
                    acc[i][ch] = 0;
                end else begin
                    acc[i][ch] += int'(mon_p[ch] === 1'b1);
                end
            end
            if (mon_t === 1'b1) begin
                ticks[i]++;
                gap[i]    = cyc - last_t[i];
                last_t[i] = cyc;
            end
        end
    end

    task automatic wait_ticks(input int i, input int n);
        int target;
        target = ticks[i] + n;
        for (int k = 0; (k < 100 * n * div_of(i)) && (ticks[i] < target); k++) @(negedge clk);
        check((i == 0) ? "tick_timeout_a" : "tick_timeout_b", 32'(ticks[i] >= target), 32'd1);
    endtask

    // ---------------- directed sequences ------------------------------------
    int hist_a[509];
    int hist_b[9];
    int post_b[5];

    task automatic seq_a();
        wait_ticks(0, 3);
        check("duty6_high", hc[0][0], 6);
        check("period_len_a", gap[0], 64);
        for (int r = 0; r < 3; r++) begin
            wait_ticks(0, 1);
            check("duty0_const_low", hc[0][1], 0);
            check("duty63_const_high", hc[0][2], 64);
            check("duty40_high", hc[0][3], 40);
            check("period_len_a", gap[0], 64);
        end
        // Mid-period duty change only takes effect next period.
        repeat (20) @(negedge clk);
        duty_a[5:0] = 6'd32;
        wait_ticks(0, 1);
        check("midchange_cur", hc[0][0], 6);
        wait_ticks(0, 1);
        check("midchange_next", hc[0][0], 32);
        // Full breathing ramp on ch0.
        duty_a[5:0] = 6'd63;
        br_a[0]     = 1'b1;
        wait_ticks(0, 1);
        for (int j = 0; j < 509; j++) begin
            wait_ticks(0, 1);
            hist_a[j] = hc[0][0];
            check("ramp_rule", hist_a[j], (env_at(j / BP) == 63) ? 64 : env_at(j / BP));
        end
        check("ramp_p0", hist_a[0], 0);
        check("ramp_p3", hist_a[3], 0);
        check("ramp_p4", hist_a[4], 1);
        check("ramp_p251", hist_a[251], 62);
        check("ramp_p252", hist_a[252], 64);
        check("ramp_p255", hist_a[255], 64);
        check("ramp_p256", hist_a[256], 62);
        check("ramp_p503", hist_a[503], 1);
        check("ramp_p504", hist_a[504], 0);
        check("ramp_p507", hist_a[507], 0);
        check("ramp_p508", hist_a[508], 1);
        // Enable drop mid-period and restart.
        br_a[0]     = 1'b0;
        duty_a[5:0] = 6'd6;
        wait_ticks(0, 2);
        check("post_ramp_duty6", hc[0][0], 6);
        repeat (10) @(negedge clk);
        en_a = 1'b0;
        @(negedge clk);
        check("disable_pwm", 32'(pwm_a), 32'd0);
        check("disable_tick", 32'(tick_a), 32'd0);
        repeat (5) @(negedge clk);
        en_a = 1'b1;
        @(negedge clk);
        check("reenable_tick", 32'(tick_a), 32'd1);
        wait_ticks(0, 1);
        check("reenable_len", gap[0], 64);
        check("reenable_duty6", hc[0][0], 6);
        check("reenable_duty63", hc[0][2], 64);
    endtask

    task automatic seq_b();
        wait_ticks(1, 3);
        check("div3_high", hc[1][0], 48);
        check("div3_period", gap[1], 192);
        duty_b[11:6] = 6'd63;
        br_b[1]      = 1'b1;
        wait_ticks(1, 1);
        for (int j = 0; j < 9; j++) begin
            wait_ticks(1, 1);
            hist_b[j] = hc[1][1];
        end
        check("div3_ramp_p0", hist_b[0], 0);
        check("div3_ramp_p4", hist_b[4], 3);
        check("div3_ramp_p8", hist_b[8], 6);
        repeat (30) @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        check("rst_mid_pwm", 32'(pwm_b), 32'd0);
        check("rst_mid_tick", 32'(tick_b), 32'd0);
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        wait_ticks(1, 1);
        for (int j = 0; j < 5; j++) begin
            wait_ticks(1, 1);
            post_b[j] = hc[1][1];
        end
        check("rst_env_p0", post_b[0], 0);
        check("rst_env_p3", post_b[3], 0);
        check("rst_env_p4", post_b[4], 3);
        check("rst_div3_high", hc[1][0], 48);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_a = 1'b0; en_a = 1'b1; br_a = 4'b0;
        rst_b = 1'b0; en_b = 1'b1; br_b = 4'b0;
        duty_a = {6'd40, 6'd63, 6'd0, 6'd6};
        duty_b = {6'd0, 6'd0, 6'd0, 6'd16};
        repeat (3) @(negedge clk);
        check("reset_pwm_a", 32'(pwm_a), 32'd0);
        check("reset_tick_a", 32'(tick_a), 32'd0);
        check("reset_pwm_b", 32'(pwm_b), 32'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        fork
            seq_a();
            seq_b();
        join
        // Randomized traffic on both instances, checked by the model every cycle.
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) duty_a = 24'($urandom);
            if ($urandom_range(0, 15) == 0) duty_b = 24'($urandom);
            if ($urandom_range(0, 31) == 0) br_a = 4'($urandom);
            if ($urandom_range(0, 31) == 0) br_b = 4'($urandom);
            en_a  = en_a ? ($urandom_range(0, 299) != 0) : ($urandom_range(0, 19) == 0);
            en_b  = en_b ? ($urandom_range(0, 299) != 0) : ($urandom_range(0, 19) == 0);
            rst_a = ($urandom_range(0, 999) != 0);
            rst_b = ($urandom_range(0, 999) != 0);
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pwm_breathe_multi
`default_nettype wire
